// File: rtl/tl_dispatch_pkg.sv
// tl_dispatch_pkg: shared FSM state type and default widths
// for the one-in / two-out FIFO dispatcher.
package tl_dispatch_pkg;

  localparam int DEF_DATA_WIDTH = 12;
  localparam int DEF_ROUTE_BIT  = 11;
  localparam int DEF_CNT_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WAIT,
    ROUTE
  } state_t;

endpackage

// File: rtl/tl_dispatch_counter.sv
// tl_dispatch_counter: wrapping per-destination word counter
// with synchronous reset and count enable.
module tl_dispatch_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // count one per enabled cycle, wrapping at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/tl_dispatch.sv
// tl_dispatch: pops one word at a time from a source FIFO and
// pushes it to dest0/dest1 by one data bit; counters under TL_DISPATCH_COUNT_EN.
module tl_dispatch
  import tl_dispatch_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ROUTE_BIT  = DEF_ROUTE_BIT,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  in_empty,
  output logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out0,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic                  push0,
  output logic                  push1,
  input  logic                  almost_full0,
  input  logic                  almost_full1,
  output logic                  stall
`ifdef TL_DISPATCH_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  count0,
  output logic [CNT_WIDTH-1:0]  count1
`endif
);

  state_t                r_state;
  logic                  r_pop;
  logic                  r_push0;
  logic                  r_push1;
  logic                  r_stall;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] r_dout0;
  logic [DATA_WIDTH-1:0] r_dout1;

  logic w_dest;
  logic w_blocked;
  logic w_deliver0;
  logic w_deliver1;

  assign w_dest     = r_hold[ROUTE_BIT];
  assign w_blocked  = w_dest ? almost_full1 : almost_full0;
  assign w_deliver0 = (r_state == ROUTE) && !w_dest && !w_blocked;
  assign w_deliver1 = (r_state == ROUTE) && w_dest && !w_blocked;

  // sequence pop -> read latency -> capture -> route, one word at a time
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pop   <= 1'b0;
      r_push0 <= 1'b0;
      r_push1 <= 1'b0;
      r_stall <= 1'b0;
      r_hold  <= '0;
      r_dout0 <= '0;
      r_dout1 <= '0;
    end else begin
      r_pop   <= 1'b0;
      r_push0 <= 1'b0;
      r_push1 <= 1'b0;
      r_stall <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (!in_empty) begin
            r_pop   <= 1'b1;
            r_state <= READ;
          end
        end
        READ: begin
          r_state <= WAIT;
        end
        WAIT: begin
          r_hold  <= data_in;
          r_state <= ROUTE;
        end
        ROUTE: begin
          if (w_blocked) begin
            r_stall <= 1'b1;
          end else begin
            if (w_dest) begin
              r_push1 <= 1'b1;
              r_dout1 <= r_hold;
            end else begin
              r_push0 <= 1'b1;
              r_dout0 <= r_hold;
            end
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign pop       = r_pop;
  assign push0     = r_push0;
  assign push1     = r_push1;
  assign stall     = r_stall;
  assign data_out0 = r_dout0;
  assign data_out1 = r_dout1;

`ifdef TL_DISPATCH_COUNT_EN
  tl_dispatch_counter #(
    .W (CNT_WIDTH)
  ) u_cnt0 (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_deliver0),
    .o_count (count0)
  );

  tl_dispatch_counter #(
    .W (CNT_WIDTH)
  ) u_cnt1 (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_deliver1),
    .o_count (count1)
  );
`else
  logic                 w_unused_deliver;
  logic [CNT_WIDTH-1:0] w_unused_cnt;
  assign w_unused_deliver = w_deliver0 | w_deliver1;
  assign w_unused_cnt     = '0;
`endif

endmodule

// File: tb/tb_tl_dispatch.sv
// tb_tl_dispatch: directed bench with a source FIFO model and an
// age-since-pop reference model compared every cycle.
module tb_tl_dispatch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] data_in = '0;
  logic        in_empty = 1'b1;
  logic        almost_full0 = 1'b0;
  logic        almost_full1 = 1'b0;
  logic        pop;
  logic        push0;
  logic        push1;
  logic        stall;
  logic [11:0] data_out0;
  logic [11:0] data_out1;
`ifdef TL_DISPATCH_COUNT_EN
  logic [7:0]  count0;
  logic [7:0]  count1;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [11:0] src_q[$];

  bit          m_busy = 1'b0;
  int          m_age = 0;
  logic [11:0] m_word = '0;
  logic        e_pop = 1'b0;
  logic        e_push0 = 1'b0;
  logic        e_push1 = 1'b0;
  logic        e_stall = 1'b0;
  logic [11:0] e_do0 = '0;
  logic [11:0] e_do1 = '0;
  logic [7:0]  e_cnt0 = '0;
  logic [7:0]  e_cnt1 = '0;

  tl_dispatch dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .in_empty     (in_empty),
    .pop          (pop),
    .data_out0    (data_out0),
    .data_out1    (data_out1),
    .push0        (push0),
    .push1        (push1),
    .almost_full0 (almost_full0),
    .almost_full1 (almost_full1),
    .stall        (stall)
`ifdef TL_DISPATCH_COUNT_EN
    ,
    .count0       (count0),
    .count1       (count1)
`endif
  );

  always #5 clk = ~clk;

  // reference model: a word popped at edge t is captured two edges
  // later and delivered at the first edge >= t+3 its dest is free
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_busy  = 1'b0;
      m_age   = 0;
      e_pop   = 1'b0;
      e_push0 = 1'b0;
      e_push1 = 1'b0;
      e_stall = 1'b0;
      e_do0   = '0;
      e_do1   = '0;
      e_cnt0  = '0;
      e_cnt1  = '0;
    end else begin
      e_pop   = 1'b0;
      e_push0 = 1'b0;
      e_push1 = 1'b0;
      e_stall = 1'b0;
      if (!m_busy) begin
        if (!in_empty) begin
          e_pop  = 1'b1;
          m_busy = 1'b1;
          m_age  = 0;
        end
      end else begin
        m_age++;
        if (m_age == 2) begin
          m_word = data_in;
        end else if (m_age >= 3) begin
          if (m_word[11] ? almost_full1 : almost_full0) begin
            e_stall = 1'b1;
          end else begin
            if (m_word[11]) begin
              e_push1 = 1'b1;
              e_do1   = m_word;
              e_cnt1  = e_cnt1 + 8'd1;
            end else begin
              e_push0 = 1'b1;
              e_do0   = m_word;
              e_cnt0  = e_cnt0 + 8'd1;
            end
            m_busy = 1'b0;
          end
        end
      end
    end
    // source FIFO with one-cycle registered read
    if (pop && src_q.size() > 0) begin
      data_in <= src_q.pop_front();
    end
    in_empty <= (src_q.size() == 0);
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (cyc > 0) begin
      checks++;
      if ({pop, push0, push1, stall, data_out0, data_out1} !==
          {e_pop, e_push0, e_push1, e_stall, e_do0, e_do1}) begin
        errors++;
        $display("FAIL cycle%0d outs got p%b q0%b q1%b s%b d0=%h d1=%h exp p%b q0%b q1%b s%b d0=%h d1=%h",
                 cyc, pop, push0, push1, stall, data_out0, data_out1,
                 e_pop, e_push0, e_push1, e_stall, e_do0, e_do1);
      end
`ifdef TL_DISPATCH_COUNT_EN
      checks++;
      if ({count0, count1} !== {e_cnt0, e_cnt1}) begin
        errors++;
        $display("FAIL cycle%0d counts got %0d/%0d exp %0d/%0d",
                 cyc, count0, count1, e_cnt0, e_cnt1);
      end
`endif
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, act, exp);
    end
  endtask

  task automatic wait_cond(input int sel, input int maxc,
                           input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      case (sel)
        0: ok = pop;
        1: ok = push0;
        2: ok = push1;
        default: ok = stall;
      endcase
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got 0 exp 1", nm);
    end
  endtask

  initial begin
    bit ok;
    int t0;
    int t1;
    int npop;
    int nst;
    int npush;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs", int'({pop, push0, push1, stall, data_out0, data_out1}), 0);
    reset = 1'b0;

    // source empty for 20 cycles
    npop = 0;
    repeat (20) begin
      @(negedge clk);
      if (pop) npop++;
    end
    chk("idle_no_pop", npop, 0);
    chk("idle_outs", int'({pop, push0, push1, stall, data_out0, data_out1}), 0);

    // single word to dest0, non-selected dest backpressured
    almost_full1 = 1'b1;
    src_q.push_back(12'h00A);
    wait_cond(0, 10, "pop_a", ok);
    t0 = cyc;
    wait_cond(1, 10, "push0_a", ok);
    chk("latency", cyc - t0, 3);
    chk("dout0_a", int'(data_out0), 12'h00A);
    chk("push1_low", int'(push1), 0);
    almost_full1 = 1'b0;

    // two words, one per destination
    src_q.push_back(12'h00A);
    src_q.push_back(12'h80B);
    wait_cond(0, 10, "pop_b1", ok);
    t0 = cyc;
    wait_cond(1, 10, "push0_b", ok);
    chk("dout0_b", int'(data_out0), 12'h00A);
    wait_cond(0, 10, "pop_b2", ok);
    t1 = cyc;
    chk("pop_gap", t1 - t0, 4);
    wait_cond(2, 10, "push1_b", ok);
    chk("dout1_b", int'(data_out1), 12'h80B);
    chk("dout0_hold", int'(data_out0), 12'h00A);

    // dest1 blocked for 5 cycles
    almost_full1 = 1'b1;
    src_q.push_back(12'h80C);
    wait_cond(3, 12, "stall_c", ok);
    nst = ok ? 1 : 0;
    repeat (4) begin
      @(negedge clk);
      if (stall) nst++;
    end
    chk("stall_cycles", nst, 5);
    almost_full1 = 1'b0;
    @(negedge clk);
    chk("push1_c", int'(push1), 1);
    chk("dout1_c", int'(data_out1), 12'h80C);
    chk("stall_off", int'(stall), 0);

    // reset while holding a blocked word
    almost_full0 = 1'b1;
    src_q.push_back(12'h00D);
    wait_cond(3, 12, "stall_d", ok);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    almost_full0 = 1'b0;
    chk("rst_outs", int'({pop, push0, push1, stall, data_out0, data_out1}), 0);
    npush = 0;
    repeat (8) begin
      @(negedge clk);
      if (push0 || push1) npush++;
    end
    chk("no_push_d", npush, 0);
    src_q.push_back(12'h00E);
    wait_cond(1, 12, "push0_e", ok);
    chk("dout0_e", int'(data_out0), 12'h00E);

`ifdef TL_DISPATCH_COUNT_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("cnt_reset", int'({count0, count1}), 0);
    for (int i = 0; i < 257; i++) begin
      logic [11:0] w;
      w = 12'(i & 12'h7FF);
      src_q.push_back(w);
    end
    npush = 0;
    for (int i = 0; i < 1400 && npush < 257; i++) begin
      @(negedge clk);
      if (push0) npush++;
    end
    chk("push0_total", npush, 257);
    chk("count0_wrap", int'(count0), 1);
    chk("count1_zero", int'(count1), 0);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
